ft60x_bus_model: RTL and testbench
==================================

// Module: ft60x_bus_model
// PURPOSE
//  Parametrised single-clock cycle model of the FT60x 245-sync FIFO bus, host side.
//  Successor to ft60x_stub. Adds:
//   - configurable bus width and host buffer depth
//   - a host drain rate
//   - a host->FPGA read path (RXF_N/OE_N/RD_N)
//   - a data-pattern checker and protocol-error counters
//  Instantiated in simulation benches opposite top, on CLK_FTDI; synthesizable for on-board loopback.
// PARAMETERS
//  DATA_W       32  bus width, 16 or 32; BE_W = DATA_W/8
//  TX_DEPTH     16  host receive-buffer depth in words (FPGA->host), >=2
//  DRAIN_PERIOD 4   host removes one word every DRAIN_PERIOD cycles, >=1
//  RX_BURST     8   words offered per host->FPGA burst, >=1
//  RX_GAP       32  idle cycles between the end of one RX burst and the start of the next
//  CNT_W        32  width of the status counters
// PORTS
//  CLK_FTDI    in   1        bus clock, all logic rising-edge
//  rst         in   1        synchronous, active-high reset
//  TXE_N       out  1        low = host can accept a write
//  WR_N        in   1        low = FPGA writes DATA_IN this cycle
//  RXF_N       out  1        low = host has data for the FPGA
//  OE_N        in   1        low = FPGA requests the model to drive the bus
//  RD_N        in   1        low = FPGA consumes DATA_OUT this cycle
//  DATA_IN     in   DATA_W   write data from FPGA
//  BE_IN       in   BE_W     write byte enables from FPGA
//  DATA_OUT    out  DATA_W   read data to FPGA
//  BE_OUT      out  BE_W     read byte enables to FPGA
//  DATA_OE     out  1        bench tristate enable for DATA/BE; equals registered !OE_N
//  tx_words    out  CNT_W    words accepted from FPGA
//  rx_words    out  CNT_W    words delivered to FPGA
//  err_data    out  CNT_W    pattern mismatches
//  err_proto   out  CNT_W    protocol violations
// BEHAVIOUR
//  Reset (sync, any cycle, including mid-burst):
//   - TXE_N=1, RXF_N=1, DATA_OE=0, DATA_OUT=0, BE_OUT=0, all counters 0
//   - tx level=0, expected pattern=0, rx pattern=0, drain and gap timers=0
//  TX path:
//   - push = !WR_N & !TXE_N; accepted word is checked in the same cycle.
//   - Check: for each byte b with BE_IN[b]=1, DATA_IN byte must equal the expected-pattern byte.
//     Any mismatch -> err_data+1. Expected pattern +1 per accepted word, wraps at 2^DATA_W.
//   - !WR_N while TXE_N=1 -> err_proto+1; the word is dropped.
//   - Drain timer counts 0..DRAIN_PERIOD-1. At wrap, pop=1 if level>0; timer never stalls.
//   - level_next = level + push - pop; simultaneous push and pop -> level unchanged.
//   - TXE_N registered: TXE_N <= (level_next==TX_DEPTH); deasserts the cycle after the last free slot is filled.
//  RX path:
//   - Gap timer runs only while avail==0. When it reaches RX_GAP-1: avail<=RX_BURST and the timer clears.
//   - RXF_N <= (avail_next==0).
//   - DATA_OE <= !OE_N. DATA_OUT = rx pattern when DATA_OE=1, else 0. BE_OUT all ones when DATA_OE=1.
//   - pop_rx = !RD_N & !RXF_N & DATA_OE; avail-1, rx pattern+1 (wraps), rx_words+1.
//   - Protocol violations, each err_proto+1, no data movement:
//      - !RD_N with DATA_OE=0 (OE_N not low on the previous cycle)
//      - !RD_N with RXF_N=1
//  Error accounting:
//   - Both err_proto sources in the same cycle -> +2.
//   - All counters saturate at all-ones.
// STRUCTURE
//  - Shared package ft60x_pkg: BE_W derivation, DATA_W legality check, pattern-width constants.
//  - One sub-module, ft60x_sat_counter (CNT_W, inc by 0..2, sync clear). Instantiated four times for the status counters.
//  - TX occupancy, drain timer, RX avail and gap timer stay inline.
// TESTING
//  1 Reset release, FPGA idle:
//    - TXE_N=0 one cycle after rst falls; RXF_N falls after RX_GAP cycles; all counters 0.
//  2 FPGA writes 0,1,2.. continuously, BE=all ones, DRAIN_PERIOD=4, TX_DEPTH=16:
//    - TXE_N high after 16+floor(16/4)-ish words, then toggles at drain rate.
//    - tx_words=100 after 100 accepted writes; err_data=0.
//  3 Write word 5 as 0xDEAD_0005, BE=4'b0001:
//    - err_data stays 0.
//    - Same word with BE=4'b1111 -> err_data=1.
//  4 WR_N low for 3 cycles while TXE_N=1:
//    - err_proto=3; tx_words unchanged.
//  5 RX burst, RX_BURST=8: OE_N low, then RD_N low one cycle later for 8 cycles:
//    - DATA_OUT reads 0..7; rx_words=8; RXF_N high on the cycle after the 8th read.
//    - RD_N without the preceding OE_N -> err_proto+1.
//  6 rst pulsed mid-RX-burst (after 3 of 8 words):
//    - All outputs return to reset values.
//    - The next burst restarts at pattern 0 after RX_GAP cycles.

Source files
------------

// File: rtl/ft60x_pkg.sv
// Shared definitions for the FT60x 245-sync bus model.
// Provides the byte-lane derivation, the bus-width legality check and the
// pattern/byte width constants used by the model and its interface.
package ft60x_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned DATA_W_NARROW = 16;
  localparam int unsigned DATA_W_WIDE   = 32;

  // Number of byte enables for a given bus width.
  function automatic int unsigned be_width(int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  // The FT60x family only exists in 16-bit (FT600) and 32-bit (FT601) variants.
  function automatic bit data_w_legal(int unsigned data_w);
    return (data_w == DATA_W_NARROW) || (data_w == DATA_W_WIDE);
  endfunction

endpackage

// File: rtl/ft60x_bus_model_if.sv
// FT60x 245-sync FIFO bus signal bundle.
//   master : FPGA side, drives WR_N/OE_N/RD_N/DATA_IN/BE_IN
//   slave  : host model side, drives TXE_N/RXF_N/DATA_OUT/BE_OUT/DATA_OE
interface ft60x_bus_model_if
  import ft60x_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);

  localparam int unsigned BE_W = be_width(DATA_W);

  logic              TXE_N;
  logic              WR_N;
  logic              RXF_N;
  logic              OE_N;
  logic              RD_N;
  logic [DATA_W-1:0] DATA_IN;
  logic [BE_W-1:0]   BE_IN;
  logic [DATA_W-1:0] DATA_OUT;
  logic [BE_W-1:0]   BE_OUT;
  logic              DATA_OE;

  modport master (
    input  TXE_N, RXF_N, DATA_OUT, BE_OUT, DATA_OE,
    output WR_N, OE_N, RD_N, DATA_IN, BE_IN
  );

  modport slave (
    output TXE_N, RXF_N, DATA_OUT, BE_OUT, DATA_OE,
    input  WR_N, OE_N, RD_N, DATA_IN, BE_IN
  );

endinterface

// File: rtl/ft60x_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i : clock, rising edge
//   clr_i : synchronous clear to zero (dominates)
//   inc_i : increment amount this cycle (0 .. 2**INC_W-1)
//   cnt_o : current count, holds at all-ones once reached
module ft60x_sat_counter #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned INC_W = 2
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + (CNT_W + 1)'(inc_i);
    // Carry out means the true value passed all-ones: clamp.
    cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ft60x_bus_model.sv
// Cycle model of the host side of an FT60x 245-sync FIFO bus.
// FPGA->host: words are accepted into a TX_DEPTH-deep host buffer that the host
// drains one word every DRAIN_PERIOD cycles; accepted data is checked against an
// incrementing pattern. Host->FPGA: bursts of RX_BURST incrementing words are
// offered after RX_GAP idle cycles.
//   CLK_FTDI  : bus clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : FT60x bus (slave side): TXE_N, WR_N, RXF_N, OE_N, RD_N,
//               DATA_IN, BE_IN, DATA_OUT, BE_OUT, DATA_OE
//   tx_words  : words accepted from the FPGA
//   rx_words  : words delivered to the FPGA
//   err_data  : accepted words that failed the pattern check
//   err_proto : protocol violations (write while full, read without OE/data)
module ft60x_bus_model
  import ft60x_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned TX_DEPTH     = 16,
  parameter int unsigned DRAIN_PERIOD = 4,
  parameter int unsigned RX_BURST     = 8,
  parameter int unsigned RX_GAP       = 32,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                CLK_FTDI,
  input  logic                rst,
  ft60x_bus_model_if.slave    bus,
  output logic [CNT_W-1:0]    tx_words,
  output logic [CNT_W-1:0]    rx_words,
  output logic [CNT_W-1:0]    err_data,
  output logic [CNT_W-1:0]    err_proto
);

  localparam int unsigned BE_W  = be_width(DATA_W);
  localparam int unsigned LVL_W = $clog2(TX_DEPTH + 1);
  localparam int unsigned DRN_W = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
  localparam int unsigned AVL_W = $clog2(RX_BURST + 1);
  localparam int unsigned GAP_W = (RX_GAP > 1) ? $clog2(RX_GAP) : 1;

  if (!data_w_legal(DATA_W)) begin : gen_bad_data_w
    $fatal(1, "ft60x_bus_model: DATA_W must be 16 or 32");
  end

  // TX path state
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic              txe_n_q, txe_n_d;
  logic [DATA_W-1:0] exp_q, exp_d;

  // RX path state
  logic [AVL_W-1:0]  avail_q, avail_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              rxf_n_q, rxf_n_d;
  logic              data_oe_q;
  logic [DATA_W-1:0] rx_pat_q, rx_pat_d;

  logic push, pop, drain_wrap, wr_while_full, mismatch;
  logic pop_rx, rd_no_oe, rd_no_rxf, gap_hit;

  // TX: acceptance, pattern check, drain and occupancy.
  always_comb begin
    push          = !bus.WR_N && !txe_n_q;
    wr_while_full = !bus.WR_N && txe_n_q;

    mismatch = 1'b0;
    for (int b = 0; b < BE_W; b++) begin
      if (bus.BE_IN[b] &&
          (bus.DATA_IN[b*BYTE_W +: BYTE_W] != exp_q[b*BYTE_W +: BYTE_W])) begin
        mismatch = 1'b1;
      end
    end
    exp_d = push ? exp_q + 1'b1 : exp_q;

    // The drain timer free-runs; a wrap with an empty buffer is simply lost.
    drain_wrap = (drain_q == DRN_W'(DRAIN_PERIOD - 1));
    drain_d    = drain_wrap ? '0 : drain_q + 1'b1;
    pop        = drain_wrap && (level_q != '0);

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
    txe_n_d = (level_d == LVL_W'(TX_DEPTH));
  end

  // RX: burst scheduling, reads and read-side protocol checks.
  always_comb begin
    rd_no_oe  = !bus.RD_N && !data_oe_q;
    rd_no_rxf = !bus.RD_N && rxf_n_q;
    pop_rx    = !bus.RD_N && !rxf_n_q && data_oe_q;

    gap_hit = (avail_q == '0) && (gap_q == GAP_W'(RX_GAP - 1));
    gap_d   = gap_q;
    if (avail_q == '0) begin
      gap_d = gap_hit ? '0 : gap_q + 1'b1;
    end

    // gap_hit needs avail==0 and pop_rx needs avail>0, so they never collide.
    avail_d = avail_q;
    if (gap_hit) begin
      avail_d = AVL_W'(RX_BURST);
    end else if (pop_rx) begin
      avail_d = avail_q - 1'b1;
    end
    rxf_n_d  = (avail_d == '0);
    rx_pat_d = pop_rx ? rx_pat_q + 1'b1 : rx_pat_q;
  end

  always_ff @(posedge CLK_FTDI) begin
    if (rst) begin
      level_q   <= '0;
      drain_q   <= '0;
      txe_n_q   <= 1'b1;
      exp_q     <= '0;
      avail_q   <= '0;
      gap_q     <= '0;
      rxf_n_q   <= 1'b1;
      data_oe_q <= 1'b0;
      rx_pat_q  <= '0;
    end else begin
      level_q   <= level_d;
      drain_q   <= drain_d;
      txe_n_q   <= txe_n_d;
      exp_q     <= exp_d;
      avail_q   <= avail_d;
      gap_q     <= gap_d;
      rxf_n_q   <= rxf_n_d;
      data_oe_q <= !bus.OE_N;
      rx_pat_q  <= rx_pat_d;
    end
  end

  assign bus.TXE_N    = txe_n_q;
  assign bus.RXF_N    = rxf_n_q;
  assign bus.DATA_OE  = data_oe_q;
  assign bus.DATA_OUT = data_oe_q ? rx_pat_q : '0;
  assign bus.BE_OUT   = data_oe_q ? '1 : '0;

  // A write-while-full can coincide with both read violations, hence 0..3.
  logic [1:0] proto_inc;
  assign proto_inc = 2'(wr_while_full) + 2'(rd_no_oe) + 2'(rd_no_rxf);

  ft60x_sat_counter #(.CNT_W(CNT_W), .INC_W(2)) u_tx_words (
    .clk_i (CLK_FTDI),
    .clr_i (rst),
    .inc_i ({1'b0, push}),
    .cnt_o (tx_words)
  );

  ft60x_sat_counter #(.CNT_W(CNT_W), .INC_W(2)) u_rx_words (
    .clk_i (CLK_FTDI),
    .clr_i (rst),
    .inc_i ({1'b0, pop_rx}),
    .cnt_o (rx_words)
  );

  ft60x_sat_counter #(.CNT_W(CNT_W), .INC_W(2)) u_err_data (
    .clk_i (CLK_FTDI),
    .clr_i (rst),
    .inc_i ({1'b0, push && mismatch}),
    .cnt_o (err_data)
  );

  ft60x_sat_counter #(.CNT_W(CNT_W), .INC_W(2)) u_err_proto (
    .clk_i (CLK_FTDI),
    .clr_i (rst),
    .inc_i (proto_inc),
    .cnt_o (err_proto)
  );

endmodule

// File: tb/tb_ft60x_bus_model.sv
// Directed bench for ft60x_bus_model with default parameters
// (DATA_W=32, TX_DEPTH=16, DRAIN_PERIOD=4, RX_BURST=8, RX_GAP=32).
module tb_ft60x_bus_model;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tx_words, rx_words, err_data, err_proto;

  always #5 clk = ~clk;

  ft60x_bus_model_if #(.DATA_W(32)) bus ();

  ft60x_bus_model #(
    .DATA_W       (32),
    .TX_DEPTH     (16),
    .DRAIN_PERIOD (4),
    .RX_BURST     (8),
    .RX_GAP       (32),
    .CNT_W        (32)
  ) dut (
    .CLK_FTDI  (clk),
    .rst       (rst),
    .bus       (bus),
    .tx_words  (tx_words),
    .rx_words  (rx_words),
    .err_data  (err_data),
    .err_proto (err_proto)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        wr_n;
    logic        oe_n;
    logic [31:0] din;
    logic [3:0]  be;
    logic        exp_data_oe;
    logic [31:0] exp_tx;
    logic [31:0] exp_ed;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: actual=%0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " TXE_N"}, 64'(bus.TXE_N), 64'd1);
    chk({tag, " RXF_N"}, 64'(bus.RXF_N), 64'd1);
    chk({tag, " DATA_OE"}, 64'(bus.DATA_OE), 64'd0);
    chk({tag, " DATA_OUT"}, 64'(bus.DATA_OUT), 64'd0);
    chk({tag, " BE_OUT"}, 64'(bus.BE_OUT), 64'd0);
    chk({tag, " tx_words"}, 64'(tx_words), 64'd0);
    chk({tag, " rx_words"}, 64'(rx_words), 64'd0);
    chk({tag, " err_data"}, 64'(err_data), 64'd0);
    chk({tag, " err_proto"}, 64'(err_proto), 64'd0);
  endtask

  initial begin
    logic [31:0] pat;
    int          tx_exp, since, first_full, win_cycles, win_acc, guard, n;
    logic        pushed;

    // Pattern words 0..9; word 5 garbage in masked lanes, word 6 garbage in a live lane,
    // word 7 with no lanes enabled, word 8/9 partially enabled.
    vecs[0]  = '{wr_n: 1'b0, oe_n: 1'b1, din: 32'h0000_0000, be: 4'hF, exp_data_oe: 1'b0, exp_tx: 1,  exp_ed: 0};
    vecs[1]  = '{wr_n: 1'b0, oe_n: 1'b1, din: 32'h0000_0001, be: 4'hF, exp_data_oe: 1'b0, exp_tx: 2,  exp_ed: 0};
    vecs[2]  = '{wr_n: 1'b0, oe_n: 1'b1, din: 32'h0000_0002, be: 4'hF, exp_data_oe: 1'b0, exp_tx: 3,  exp_ed: 0};
    vecs[3]  = '{wr_n: 1'b0, oe_n: 1'b1, din: 32'h0000_0003, be: 4'hF, exp_data_oe: 1'b0, exp_tx: 4,  exp_ed: 0};
    vecs[4]  = '{wr_n: 1'b0, oe_n: 1'b1, din: 32'h0000_0004, be: 4'hF, exp_data_oe: 1'b0, exp_tx: 5,  exp_ed: 0};
    vecs[5]  = '{wr_n: 1'b0, oe_n: 1'b1, din: 32'hDEAD_0005, be: 4'h1, exp_data_oe: 1'b0, exp_tx: 6,  exp_ed: 0};
    vecs[6]  = '{wr_n: 1'b0, oe_n: 1'b1, din: 32'hDEAD_0006, be: 4'hF, exp_data_oe: 1'b0, exp_tx: 7,  exp_ed: 1};
    vecs[7]  = '{wr_n: 1'b0, oe_n: 1'b1, din: 32'hFFFF_FFFF, be: 4'h0, exp_data_oe: 1'b0, exp_tx: 8,  exp_ed: 1};
    vecs[8]  = '{wr_n: 1'b0, oe_n: 1'b1, din: 32'h1234_0008, be: 4'h3, exp_data_oe: 1'b0, exp_tx: 9,  exp_ed: 1};
    vecs[9]  = '{wr_n: 1'b0, oe_n: 1'b1, din: 32'h0001_0009, be: 4'h4, exp_data_oe: 1'b0, exp_tx: 10, exp_ed: 2};
    vecs[10] = '{wr_n: 1'b1, oe_n: 1'b0, din: 32'h0000_0000, be: 4'h0, exp_data_oe: 1'b1, exp_tx: 10, exp_ed: 2};
    vecs[11] = '{wr_n: 1'b1, oe_n: 1'b1, din: 32'h0000_0000, be: 4'h0, exp_data_oe: 1'b0, exp_tx: 10, exp_ed: 2};

    rst         = 1'b1;
    bus.WR_N    = 1'b1;
    bus.OE_N    = 1'b1;
    bus.RD_N    = 1'b1;
    bus.DATA_IN = '0;
    bus.BE_IN   = '0;
    tick();
    tick();
    chk_reset("reset");

    // Reset release, FPGA idle.
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 1)  chk("txe_after_release", 64'(bus.TXE_N), 64'd0);
      if (i == 31) chk("rxf_before_gap", 64'(bus.RXF_N), 64'd1);
    end
    chk("rxf_after_gap", 64'(bus.RXF_N), 64'd0);
    chk("idle_tx_words", 64'(tx_words), 64'd0);

    // Read with data available but no preceding OE_N.
    bus.RD_N = 1'b0;
    tick();
    bus.RD_N = 1'b1;
    chk("rd_no_oe err_proto", 64'(err_proto), 64'd1);
    chk("rd_no_oe rx_words", 64'(rx_words), 64'd0);
    chk("rd_no_oe rxf", 64'(bus.RXF_N), 64'd0);

    // Legal 8-word burst.
    bus.OE_N = 1'b0;
    tick();
    chk("oe data_oe", 64'(bus.DATA_OE), 64'd1);
    chk("oe be_out", 64'(bus.BE_OUT), 64'hF);
    bus.RD_N = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("burst data %0d", i), 64'(bus.DATA_OUT), 64'(i));
      chk($sformatf("burst rxf %0d", i), 64'(bus.RXF_N), 64'd0);
      tick();
    end
    chk("burst rx_words", 64'(rx_words), 64'd8);
    chk("burst rxf_end", 64'(bus.RXF_N), 64'd1);
    chk("burst err_proto", 64'(err_proto), 64'd1);

    bus.OE_N = 1'b1;
    bus.RD_N = 1'b1;
    tick();
    chk("oe_off data_oe", 64'(bus.DATA_OE), 64'd0);
    chk("oe_off data_out", 64'(bus.DATA_OUT), 64'd0);
    chk("oe_off be_out", 64'(bus.BE_OUT), 64'd0);

    // No OE and no data: two violations in one cycle.
    bus.RD_N = 1'b0;
    tick();
    bus.RD_N = 1'b1;
    chk("double_violation err_proto", 64'(err_proto), 64'd3);
    // OE asserted but no data.
    bus.OE_N = 1'b0;
    tick();
    bus.RD_N = 1'b0;
    tick();
    bus.RD_N = 1'b1;
    bus.OE_N = 1'b1;
    chk("rd_no_rxf err_proto", 64'(err_proto), 64'd4);
    chk("rd_no_rxf rx_words", 64'(rx_words), 64'd8);
    tick();

    // Table-driven TX pattern checks.
    for (int i = 0; i < 12; i++) begin
      bus.WR_N    = vecs[i].wr_n;
      bus.OE_N    = vecs[i].oe_n;
      bus.DATA_IN = vecs[i].din;
      bus.BE_IN   = vecs[i].be;
      tick();
      chk($sformatf("vec%0d tx_words", i), 64'(tx_words), 64'(vecs[i].exp_tx));
      chk($sformatf("vec%0d err_data", i), 64'(err_data), 64'(vecs[i].exp_ed));
      chk($sformatf("vec%0d data_oe", i), 64'(bus.DATA_OE), 64'(vecs[i].exp_data_oe));
      chk($sformatf("vec%0d txe_n", i), 64'(bus.TXE_N), 64'd0);
    end
    bus.WR_N = 1'b1;
    bus.OE_N = 1'b1;
    chk("table err_proto", 64'(err_proto), 64'd4);

    // Let the host buffer drain completely.
    for (int i = 0; i < 80; i++) tick();
    chk("drained txe_n", 64'(bus.TXE_N), 64'd0);

    // Continuous writes until 100 words total; fill and steady-state rate.
    pat        = 32'd10;
    tx_exp     = 10;
    since      = 0;
    first_full = -1;
    win_cycles = 0;
    win_acc    = 0;
    for (int c = 0; c < 2000 && tx_exp < 100; c++) begin
      pushed      = (bus.TXE_N == 1'b0);
      bus.WR_N    = !pushed;
      bus.DATA_IN = pat;
      bus.BE_IN   = 4'hF;
      tick();
      if (pushed) begin
        pat++;
        tx_exp++;
        since++;
      end
      if (first_full >= 0 && win_cycles < 40) begin
        win_cycles++;
        if (pushed) win_acc++;
      end
      if (first_full < 0 && bus.TXE_N == 1'b1) first_full = since;
    end
    bus.WR_N = 1'b1;
    chk_range("words_until_full", first_full, 20, 22);
    chk_range("full_rate_40cyc", win_acc, 9, 11);
    chk("tx_words_100", 64'(tx_words), 64'd100);
    chk("stream err_data", 64'(err_data), 64'd2);
    chk("stream err_proto", 64'(err_proto), 64'd4);

    // Fill, wait for a drain slot, refill, then write three times while full.
    guard = 0;
    while (bus.TXE_N == 1'b0 && guard < 50) begin
      bus.WR_N    = 1'b0;
      bus.DATA_IN = pat;
      tick();
      pat++;
      tx_exp++;
      guard++;
    end
    bus.WR_N = 1'b1;
    chk("refill txe_n", 64'(bus.TXE_N), 64'd1);
    guard = 0;
    while (bus.TXE_N == 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    chk("slot txe_n", 64'(bus.TXE_N), 64'd0);
    bus.WR_N    = 1'b0;
    bus.DATA_IN = pat;
    tick();
    pat++;
    tx_exp++;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("full txe_n %0d", k), 64'(bus.TXE_N), 64'd1);
      bus.WR_N    = 1'b0;
      bus.DATA_IN = 32'hBAD0_0000 | 32'(k);
      tick();
    end
    bus.WR_N = 1'b1;
    chk("wr_full err_proto", 64'(err_proto), 64'd7);
    chk("wr_full tx_words", 64'(tx_words), 64'(tx_exp));
    chk("wr_full err_data", 64'(err_data), 64'd2);

    // Reset in the middle of an RX burst.
    guard = 0;
    while (bus.RXF_N == 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    chk("rx_refill rxf", 64'(bus.RXF_N), 64'd0);
    bus.OE_N = 1'b0;
    tick();
    bus.RD_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("burst2 data %0d", i), 64'(bus.DATA_OUT), 64'(8 + i));
      tick();
    end
    chk("burst2 rx_words", 64'(rx_words), 64'd11);
    rst = 1'b1;
    tick();
    chk_reset("midburst_reset");
    rst      = 1'b0;
    bus.RD_N = 1'b1;
    bus.OE_N = 1'b1;
    n = 0;
    while (bus.RXF_N == 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("post_reset gap", 64'(n), 64'd32);
    bus.OE_N = 1'b0;
    tick();
    chk("post_reset data0", 64'(bus.DATA_OUT), 64'd0);
    bus.RD_N = 1'b0;
    tick();
    bus.RD_N = 1'b1;
    bus.OE_N = 1'b1;
    chk("post_reset rx_words", 64'(rx_words), 64'd1);
    chk("post_reset data1", 64'(bus.DATA_OUT), 64'd1);
    chk("post_reset err_proto", 64'(err_proto), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
